// File: rtl/neuron_layer_ctrl.sv
// neuron_layer_ctrl: steps one shared neuron across M weight rows to form a fully connected layer.
// Rows load through the config port while idle; results are presented as one packed vector.
module neuron_layer_ctrl #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int M     = 4,
    parameter int AW    = 2,
    localparam int YW   = 2*WIDTH+2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we_i,
    input  logic [AW-1:0]        cfg_addr_i,
    input  logic [N*WIDTH-1:0]   cfg_w_i,
    input  logic [WIDTH-1:0]     cfg_b_i,
    output logic                 busy_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*WIDTH-1:0]   in_x_i,
    output logic [N*WIDTH-1:0]   nrn_x_o,
    output logic [N*WIDTH-1:0]   nrn_w_o,
    output logic [WIDTH-1:0]     nrn_b_o,
    input  logic [YW-1:0]        nrn_y_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [M*YW-1:0]      out_y_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q;
    logic [AW-1:0]        idx_q;
    logic [N*WIDTH-1:0]   x_q;
    logic [N*WIDTH-1:0]   w_q [M];
    logic [WIDTH-1:0]     b_q [M];
    logic [YW-1:0]        y_q [M];
    logic                 cfg_ok;
    // AW+1 bits hold M exactly even when M == 2**AW
    assign cfg_ok = cfg_we_i && state_q == IDLE && ({1'b0, cfg_addr_i} < (AW+1)'(M));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            for (int j = 0; j < M; j++) begin
                w_q[j] <= '0;
                b_q[j] <= '0;
                y_q[j] <= '0;
            end
        end else begin
            if (cfg_ok) begin
                w_q[cfg_addr_i] <= cfg_w_i;
                b_q[cfg_addr_i] <= cfg_b_i;
            end
            case (state_q)
                IDLE: if (in_valid_i) begin
                    x_q     <= in_x_i;
                    idx_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    y_q[idx_q] <= nrn_y_i;
                    if (idx_q == AW'(M-1)) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                DONE: if (out_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o      = state_q != IDLE;
    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign nrn_x_o     = x_q;
    assign nrn_w_o     = w_q[idx_q];
    assign nrn_b_o     = b_q[idx_q];
    always_comb begin
        out_y_o = '0;
        for (int j = 0; j < M; j++) out_y_o[j*YW +: YW] = y_q[j];
    end
endmodule
